// File: rtl/vga_pkg.sv
// Shared VGA plotting definitions: command opcodes, plotter states, default resolution.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_PIXEL = 2'b01,
        OP_RECT  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PIXEL = 2'b01,
        ST_FILL  = 2'b10
    } state_e;

endpackage

// File: rtl/plot_raster_counter.sv
// Raster stepper: i walks 0..w-1 inside j walking 0..h-1, flags the final coordinate.
// Latency: i_nxt/j_nxt/last are combinational from the registered i/j; they advance one step per step pulse.
// Backpressure: none; the owner decides when to pulse step.
// Ports: clk/reset, start (zero i,j), step (advance), w/h (extent),
//        i_nxt/j_nxt (coordinate after the next step), last (current coordinate is final).
module plot_raster_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] w,
    input  logic [7:0] h,
    output logic [7:0] i_nxt,
    output logic [7:0] j_nxt,
    output logic       last
);

    logic [7:0] i;
    logic [7:0] j;
    logic       row_end;

    assign row_end = (i == w - 8'd1);
    assign i_nxt   = row_end ? 8'd0 : i + 8'd1;
    assign j_nxt   = row_end ? j + 8'd1 : j;
    // An empty extent has no coordinates, so the single cycle spent is already the last one.
    assign last    = (w == 8'd0) || (h == 8'd0) || (row_end && (j == h - 8'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i <= 8'd0;
            j <= 8'd0;
        end else if (start) begin
            i <= 8'd0;
            j <= 8'd0;
        end else if (step) begin
            i <= i_nxt;
            j <= j_nxt;
        end
    end

endmodule

// File: rtl/pixel_plotter.sv
// Pixel plotter: turns PIXEL/RECT/CLEAR commands into a stream of clipped plot strobes for the VGA adapter.
// Latency: first plot in the cycle after acceptance, then one coordinate per cycle.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, not queued.
// Ports: clk/reset, cmd_valid/cmd_ready/cmd_op + arg_x/arg_y/arg_w/arg_h/arg_colour in,
//        registered x/y/colour/plot to the adapter, busy = !cmd_ready.
module pixel_plotter
    import vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] arg_x,
    input  logic [7:0] arg_y,
    input  logic [7:0] arg_w,
    input  logic [7:0] arg_h,
    input  logic [2:0] arg_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [8:0] H_LIM  = 9'(H_RES);
    localparam logic [8:0] V_LIM  = 9'(V_RES);
    localparam logic [7:0] H_SIZE = 8'(H_RES);
    localparam logic [7:0] V_SIZE = 8'(V_RES);

    state_e     state;
    op_e        op;
    logic [7:0] base_x, base_y;
    logic [7:0] rect_w, rect_h;
    logic [7:0] i_nxt, j_nxt;
    logic       last;
    logic       accept;
    logic       step;
    logic [7:0] org_x, org_y, off_x, off_y;
    logic [8:0] sum_x, sum_y;
    logic       visible;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign step      = (state == ST_FILL) && !last;

    plot_raster_counter u_raster (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .step  (step),
        .w     (rect_w),
        .h     (rect_h),
        .i_nxt (i_nxt),
        .j_nxt (j_nxt),
        .last  (last)
    );

    // One adder pair serves both the first coordinate (taken straight from the
    // command at acceptance) and every later step of the raster.
    always_comb begin
        org_x = base_x;
        org_y = base_y;
        off_x = i_nxt;
        off_y = j_nxt;
        if (state == ST_IDLE) begin
            off_x = 8'd0;
            off_y = 8'd0;
            org_x = (op == OP_CLEAR) ? 8'd0 : arg_x;
            org_y = (op == OP_CLEAR) ? 8'd0 : arg_y;
        end
        sum_x   = {1'b0, org_x} + {1'b0, off_x};
        sum_y   = {1'b0, org_y} + {1'b0, off_y};
        visible = (sum_x < H_LIM) && (sum_y < V_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
            base_x <= 8'd0;
            base_y <= 8'd0;
            rect_w <= 8'd0;
            rect_h <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    if (cmd_valid) begin
                        case (op)
                            OP_PIXEL: begin
                                state  <= ST_PIXEL;
                                x      <= sum_x[7:0];
                                y      <= sum_y[6:0];
                                colour <= arg_colour;
                                plot   <= visible;
                            end
                            OP_RECT, OP_CLEAR: begin
                                state  <= ST_FILL;
                                base_x <= org_x;
                                base_y <= org_y;
                                rect_w <= (op == OP_CLEAR) ? H_SIZE : arg_w;
                                rect_h <= (op == OP_CLEAR) ? V_SIZE : arg_h;
                                x      <= sum_x[7:0];
                                y      <= sum_y[6:0];
                                colour <= arg_colour;
                                // An empty rectangle still burns its one FILL cycle, dark.
                                plot   <= visible && ((op == OP_CLEAR) ||
                                                      ((arg_w != 8'd0) && (arg_h != 8'd0)));
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PIXEL: begin
                    state <= ST_IDLE;
                    plot  <= 1'b0;
                end
                ST_FILL: begin
                    if (last) begin
                        state <= ST_IDLE;
                        plot  <= 1'b0;
                    end else begin
                        x    <= sum_x[7:0];
                        y    <= sum_y[6:0];
                        plot <= visible;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed bench for pixel_plotter: hand-computed commands, per-cycle raster model for plotted coordinates.
// Latency: samples 1 ns after each rising edge.
// Backpressure: exercises commands offered while busy and back-to-back acceptance.
module tb_pixel_plotter;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] arg_x, arg_y, arg_w, arg_h;
    logic [2:0] arg_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int last_px = -1;
    int last_py = -1;

    pixel_plotter #(.H_RES(160), .V_RES(120)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .arg_x      (arg_x),
        .arg_y      (arg_y),
        .arg_w      (arg_w),
        .arg_h      (arg_h),
        .arg_colour (arg_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, then walk its busy window checking every cycle against
    // a raster model. exp_busy / exp_plots are hand-computed by the caller.
    task automatic do_cmd(input string tag, input logic [1:0] op,
                          input int ax, input int ay, input int aw, input int ah,
                          input int col, input int exp_busy, input int exp_plots);
        int ex, ey, ew, eh, nb, np, xs, ys;
        logic eplot;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        arg_x      = 8'(ax);
        arg_y      = 8'(ay);
        arg_w      = 8'(aw);
        arg_h      = 8'(ah);
        arg_colour = 3'(col);
        tick();
        cmd_valid = 1'b0;
        ex = ax; ey = ay; ew = aw; eh = ah;
        if (op == 2'b01) begin ew = 1; eh = 1; end
        if (op == 2'b11) begin ex = 0; ey = 0; ew = 160; eh = 120; end
        nb = 0;
        np = 0;
        while (busy === 1'b1 && nb < 20000) begin
            if (op == 2'b00 || ew == 0 || eh == 0) begin
                eplot = 1'b0;
                xs = 0; ys = 0;
            end else begin
                xs = ex + (nb % ew);
                ys = ey + (nb / ew);
                eplot = (xs < 160) && (ys < 120);
            end
            if (eplot) begin
                chk({tag, "_pix"}, int'({plot, x, y, colour}),
                    int'({1'b1, 8'(xs), 7'(ys), 3'(col)}));
            end else begin
                chk({tag, "_dark"}, int'(plot), 0);
            end
            if (plot === 1'b1) begin
                np++;
                last_px = int'(x);
                last_py = int'(y);
            end
            nb++;
            tick();
        end
        chk({tag, "_busy_cycles"}, nb, exp_busy);
        chk({tag, "_plot_count"}, np, exp_plots);
        chk({tag, "_ready_after"}, int'({cmd_ready, busy, plot}), int'(3'b100));
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        arg_x      = 8'd0;
        arg_y      = 8'd0;
        arg_w      = 8'd0;
        arg_h      = 8'd0;
        arg_colour = 3'd0;
        tick();
        tick();
        chk("reset_outputs", int'({plot, x, y, colour}), 0);
        chk("reset_ready_busy", int'({cmd_ready, busy}), int'(2'b10));
        reset = 1'b0;

        // First command taken at the first edge after reset release.
        cmd_valid = 1'b1; cmd_op = 2'b01;
        arg_x = 8'd10; arg_y = 8'd20; arg_colour = 3'd5;
        tick();
        cmd_valid = 1'b0;
        chk("pixel_strobe", int'({plot, x, y, colour}), int'({1'b1, 8'd10, 7'd20, 3'd5}));
        chk("pixel_busy", int'({cmd_ready, busy}), int'(2'b01));
        tick();
        chk("pixel_done", int'({plot, cmd_ready, busy}), int'(3'b010));

        do_cmd("nop", 2'b00, 1, 1, 1, 1, 1, 0, 0);
        do_cmd("pixel2", 2'b01, 159, 119, 0, 0, 7, 1, 1);
        do_cmd("rect2x2", 2'b10, 3, 4, 2, 2, 2, 4, 4);
        do_cmd("rect_clip", 2'b10, 158, 118, 4, 3, 1, 12, 4);
        chk("rect_clip_last_x", last_px, 159);
        chk("rect_clip_last_y", last_py, 119);
        do_cmd("rect_w0", 2'b10, 5, 5, 0, 7, 3, 1, 0);
        do_cmd("rect_h0", 2'b10, 5, 5, 7, 0, 3, 1, 0);
        do_cmd("clear", 2'b11, 9, 9, 9, 9, 0, 19200, 19200);
        chk("clear_last_x", last_px, 159);
        chk("clear_last_y", last_py, 119);

        // Offers while busy are ignored; the held offer lands on the return cycle.
        cmd_valid = 1'b1; cmd_op = 2'b10;
        arg_x = 8'd3; arg_y = 8'd4; arg_w = 8'd2; arg_h = 8'd2; arg_colour = 3'd2;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("held_rect_pix", int'({plot, x, y, colour}),
                int'({1'b1, 8'(3 + k % 2), 7'(4 + k / 2), 3'd2}));
            cmd_op = (k % 2 == 0) ? 2'b11 : 2'b01;
            arg_x = 8'(77 + k); arg_y = 8'(30 + k); arg_w = 8'd9; arg_h = 8'd9;
            arg_colour = 3'(4 + k);
            tick();
        end
        chk("held_return_ready", int'({cmd_ready, plot}), int'(2'b10));
        tick();
        cmd_valid = 1'b0;
        chk("held_next_pixel", int'({plot, x, y, colour}), int'({1'b1, 8'd80, 7'd33, 3'd7}));
        tick();
        chk("held_next_done", int'({cmd_ready, plot}), int'(2'b10));

        // Reset in the middle of a CLEAR.
        cmd_valid = 1'b1; cmd_op = 2'b11; arg_colour = 3'd3;
        tick();
        cmd_valid = 1'b0;
        repeat (49) tick();
        chk("clear_running", int'({busy, plot, colour}), int'({1'b1, 1'b1, 3'd3}));
        reset = 1'b1;
        #1;
        chk("midreset_outputs", int'({plot, x, y, colour}), 0);
        chk("midreset_ready_busy", int'({cmd_ready, busy}), int'(2'b10));
        #2;
        reset = 1'b0;
        do_cmd("pixel_after_reset", 2'b01, 1, 2, 0, 0, 6, 1, 1);
        chk("pixel_after_reset_x", last_px, 1);
        chk("pixel_after_reset_y", last_py, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_plotter.md
PIXEL_PLOTTER -- requirements
Module: pixel_plotter

Interface
REQ-001 Parameter H_RES, default 160, meaning horizontal plot resolution in pixels.
REQ-002 Parameter V_RES, default 120, meaning vertical plot resolution in pixels.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present on the cmd_* / arg_* inputs.
REQ-006 cmd_ready  output  1  block able to accept a command this cycle.
REQ-007 cmd_op  input  2  operation: 00 NOP, 01 PIXEL, 10 RECT, 11 CLEAR.
REQ-008 arg_x  input  8  start column; arg_y  input  8  start row.
REQ-009 arg_w  input  8  rectangle width; arg_h  input  8  rectangle height.
REQ-010 arg_colour  input  3  fill colour.
REQ-011 x  output  8  plot column to the VGA adapter; y  output  7  plot row.
REQ-012 colour  output  3  plot colour; plot  output  1  write strobe, one pixel per high cycle.
REQ-013 busy  output  1  operation in progress; equals NOT cmd_ready.

Function
REQ-014 The block SHALL implement states IDLE, PIXEL, FILL; cmd_ready SHALL be high only in IDLE.
REQ-015 A command is accepted on a cycle with cmd_valid and cmd_ready both high; all arguments are captured on that edge and later input changes have no effect.
REQ-016 NOP accepted SHALL leave the block in IDLE with no plot.
REQ-017 PIXEL accepted at edge N SHALL drive plot high for exactly the cycle after N with x=arg_x, y=arg_y[6:0], colour=arg_colour, then return to IDLE.
REQ-018 RECT SHALL visit (arg_x+i, arg_y+j) for j=0..h-1 outer, i=0..w-1 inner, one coordinate per cycle, first coordinate in the cycle after acceptance.
REQ-019 CLEAR SHALL behave as RECT with origin (0,0), w=H_RES, h=V_RES; arg_x/arg_y/arg_w/arg_h ignored.
REQ-020 Coordinate sums SHALL be computed at 9 bits; any coordinate with column >= H_RES or row >= V_RES is clipped: the cycle is spent, plot low.
REQ-021 RECT with w=0 or h=0 SHALL spend one cycle in FILL with plot low, then return to IDLE.
REQ-022 FILL SHALL return to IDLE in the cycle after the last coordinate (i=w-1, j=h-1); cmd_ready high in that cycle, so back-to-back commands incur no extra gap.
REQ-023 Total busy cycles: PIXEL 1, RECT max(w*h,1), CLEAR H_RES*V_RES.
REQ-024 Outputs x, y, colour SHALL be registered; plot low whenever the block is in IDLE.
REQ-025 cmd_valid during busy SHALL be ignored (not queued).

Reset
REQ-026 Assertion of reset, including mid-FILL, SHALL immediately force state IDLE, plot=0, x=0, y=0, colour=0, cmd_ready=1, busy=0 and discard the current operation.
REQ-027 The first command SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-028 Op encodings (OP_NOP, OP_PIXEL, OP_RECT, OP_CLEAR), state encodings and default H_RES/V_RES SHALL live in the shared vga package.
REQ-029 The i/j raster stepping with wrap and last-pixel detect SHALL be one sub-module, plot_raster_counter.
REQ-030 pixel_plotter SHALL connect between the cpu output ports and the vga adapter x/y/colour/plot inputs inside the top-level integration.

Verification
REQ-031 PIXEL x=10,y=20,colour=5 -> one plot cycle at acceptance+1 with x=10,y=20,colour=5; cmd_ready high next cycle.
REQ-032 RECT x=3,y=4,w=2,h=2,colour=2 -> plots (3,4),(4,4),(3,5),(4,5) on four consecutive cycles; busy exactly 4 cycles.
REQ-033 RECT x=158,y=118,w=4,h=3 -> 12 busy cycles, plot high only for (158,118),(159,118),(158,119),(159,119).
REQ-034 CLEAR colour=0 -> 19200 busy cycles, 19200 plots, last at (159,119); RECT w=0,h=7 -> 1 busy cycle, no plot.
REQ-035 Reset asserted at cycle 50 of a CLEAR -> plot low and cmd_ready high same cycle; PIXEL issued after release is plotted normally.
REQ-036 cmd_valid held high with changing args during a RECT -> ignored; next command accepted on the REQ-022 return cycle with no gap.
